// File: rtl/z80_stack_engine.sv
// Multi-cycle PUSH/POP engine: moves one DATA_BYTES-wide word between a request
// port and a byte-wide memory port, one byte per memory handshake.
module z80_stack_engine #(
  parameter int DATA_BYTES = 2,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_push,
  input  logic [ADDR_WIDTH-1:0]   req_sp,
  input  logic [8*DATA_BYTES-1:0] req_data,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_rd,
  output logic                    mem_wr,
  output logic [7:0]              mem_wdata,
  input  logic [7:0]              mem_rdata,
  input  logic                    mem_ready,
  output logic                    rsp_valid,
  output logic [8*DATA_BYTES-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0]   rsp_sp
);

  localparam int KW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(DATA_BYTES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                          state, state_nxt;
  logic                            push_q;
  logic [ADDR_WIDTH-1:0]           sp_q;
  logic [DATA_BYTES-1:0][7:0]      data_q;
  logic [DATA_BYTES-1:0][7:0]      pop_word;
  logic [KW-1:0]                   k_q;
  logic                            accept;
  logic                            hs;
  logic                            last_byte;

  // PUSH walks downward from sp-1, POP upward from sp; both wrap modulo 2^ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] byte_addr(input logic push,
                                                      input logic [ADDR_WIDTH-1:0] sp,
                                                      input logic [KW-1:0] k);
    if (push) byte_addr = sp - ADDR_WIDTH'(k) - ADDR_WIDTH'(1);
    else      byte_addr = sp + ADDR_WIDTH'(k);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] final_sp(input logic push,
                                                     input logic [ADDR_WIDTH-1:0] sp);
    if (push) final_sp = sp - ADDR_WIDTH'(DATA_BYTES);
    else      final_sp = sp + ADDR_WIDTH'(DATA_BYTES);
  endfunction

  assign accept    = req_valid && req_ready;
  assign hs        = (state == ACCESS) && mem_ready;
  assign last_byte = (k_q == K_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = ACCESS;
      ACCESS:  if (mem_ready && last_byte) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE:   req_ready = 1'b1;
      ACCESS: begin
        mem_rd   = !push_q;
        mem_wr   = push_q;
        mem_addr = byte_addr(push_q, sp_q, k_q);
        if (push_q) mem_wdata = data_q[K_LAST - k_q];
      end
      DONE:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // POP assembles the result in place over the latched request word.
  always_comb begin
    pop_word      = data_q;
    pop_word[k_q] = mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      push_q   <= 1'b0;
      sp_q     <= '0;
      data_q   <= '0;
      k_q      <= '0;
      rsp_data <= '0;
      rsp_sp   <= '0;
    end else if (accept) begin
      push_q <= req_push;
      sp_q   <= req_sp;
      data_q <= req_data;
      k_q    <= '0;
    end else if (hs) begin
      if (!push_q) data_q <= pop_word;
      if (last_byte) begin
        rsp_data <= push_q ? data_q : pop_word;
        rsp_sp   <= final_sp(push_q, sp_q);
      end else begin
        k_q <= k_q + 1'b1;
      end
    end
  end

endmodule
